// File: rtl/cam_part_ctrl_pkg.sv
// rtl/cam_part_ctrl_pkg.sv - state encoding and init-data mode constants; INIT state exists only with CAM_PART_INIT_EN
package cam_part_ctrl_pkg;

  // Init data modes: zero fill, or sequential values starting at SEQ_START
  localparam int RESET_ZERO_MODE = 0;
  localparam int RESET_SEQ_MODE  = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_GATE   = 3'd2,
    S_UNGATE = 3'd3,
    S_WAKE   = 3'd4
`ifdef CAM_PART_INIT_EN
    , S_INIT = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/cam_part_init_walker.sv
// rtl/cam_part_init_walker.sv - rewrites every entry of the masked partitions (used only with CAM_PART_INIT_EN)
module cam_part_init_walker import cam_part_ctrl_pkg::*; #(
  parameter int DEPTH         = 32,
  parameter int INDEX         = 5,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int WIDTH         = 8,
  parameter int SEQ_MODE      = RESET_ZERO_MODE,
  parameter int SEQ_START     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [NUM_PARTS-1:0] mask_i,
  input  logic                 gnt_i,
  output logic                 wr_en_o,
  output logic [INDEX-1:0]     addr_o,
  output logic [WIDTH-1:0]     data_o,
  output logic                 done_o
);

  localparam int ENTRY_W    = INDEX - NUM_PARTS_LOG;
  localparam int LAST_ENTRY = DEPTH / NUM_PARTS - 1;

  logic                     busy_q, busy_d;
  logic [NUM_PARTS_LOG-1:0] part_q, part_d;
  logic [ENTRY_W-1:0]       entry_q, entry_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic [NUM_PARTS_LOG-1:0] first_part, next_part;
  logic                     has_next;
  logic                     last_entry;
  logic [INDEX-1:0]         addr_d;

  // Lowest masked partition overall, and lowest masked partition above the current one
  always_comb begin
    first_part = '0;
    next_part  = '0;
    has_next   = 1'b0;
    for (int i = NUM_PARTS - 1; i >= 0; i--) begin
      if (mask_i[i]) first_part = NUM_PARTS_LOG'(i);
      if (mask_i[i] && (i > int'(part_q))) begin
        next_part = NUM_PARTS_LOG'(i);
        has_next  = 1'b1;
      end
    end
  end

  assign last_entry = (entry_q == ENTRY_W'(LAST_ENTRY));
  assign done_o     = busy_q & gnt_i & last_entry & ~has_next;
  assign wr_en_o    = busy_q;
  assign addr_o     = {part_q, entry_q};
  assign data_o     = data_q;

  // Walker advances only on granted cycles; data is precomputed from the next address
  always_comb begin
    busy_d  = busy_q;
    part_d  = part_q;
    entry_d = entry_q;
    if (start_i) begin
      busy_d  = 1'b1;
      part_d  = first_part;
      entry_d = '0;
    end else if (busy_q && gnt_i) begin
      if (last_entry) begin
        if (has_next) begin
          part_d  = next_part;
          entry_d = '0;
        end else begin
          busy_d  = 1'b0;
          part_d  = '0;
          entry_d = '0;
        end
      end else begin
        entry_d = entry_q + ENTRY_W'(1);
      end
    end
    addr_d = {part_d, entry_d};
    data_d = ((SEQ_MODE == RESET_SEQ_MODE) && busy_d) ? WIDTH'(SEQ_START + int'(addr_d)) : '0;
  end

  // Walker registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      part_q  <= '0;
      entry_q <= '0;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      part_q  <= part_d;
      entry_q <= entry_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cam_part_gate_ctrl.sv
// rtl/cam_part_gate_ctrl.sv - partition drain/gate/ungate sequencer; CAM_PART_INIT_EN adds post-wake reinit
module cam_part_gate_ctrl import cam_part_ctrl_pkg::*; #(
  parameter int DEPTH         = 32,
  parameter int INDEX         = 5,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int WIDTH         = 8,
  parameter int RESET_SEQ     = RESET_ZERO_MODE,
  parameter int SEQ_START     = 0,
  parameter int WAKE_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reqValid_i,
  input  logic [NUM_PARTS-1:0] partActiveReq_i,
  output logic                 reqReady_o,
  input  logic [NUM_PARTS-1:0] partEmpty_i,
  output logic [NUM_PARTS-1:0] drainReq_o,
  output logic [NUM_PARTS-1:0] partitionGated_o,
  output logic                 initWrEn_o,
  output logic [INDEX-1:0]     initAddr_o,
  output logic [WIDTH-1:0]     initData_o,
  input  logic                 initWrGnt_i,
  input  logic                 ramReady_i,
  output logic [NUM_PARTS-1:0] partReady_o,
  output logic                 busy_o
);

  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [NUM_PARTS-1:0] active_q, active_d;
  logic [NUM_PARTS-1:0] req_q, req_d;
  logic [NUM_PARTS-1:0] to_gate_q, to_gate_d;
  logic [NUM_PARTS-1:0] to_ungate_q, to_ungate_d;
  logic [NUM_PARTS-1:0] gated_q, gated_d;
  logic [NUM_PARTS-1:0] drain_q, drain_d;
  logic [WAKE_W-1:0]    wake_cnt_q, wake_cnt_d;
  logic [NUM_PARTS-1:0] req_w, to_gate_w, to_ungate_w;
  logic                 busy;
`ifdef CAM_PART_INIT_EN
  logic                 init_start;
  logic                 init_done;
`endif

  // Partition 0 can never be gated, so it is forced into every request
  assign req_w       = partActiveReq_i | NUM_PARTS'(1);
  assign to_gate_w   = active_q & ~req_w;
  assign to_ungate_w = ~active_q & req_w;

  // Next-state and output-register computation; gate/ungate masks take effect on state entry
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    req_d       = req_q;
    to_gate_d   = to_gate_q;
    to_ungate_d = to_ungate_q;
    gated_d     = gated_q;
    drain_d     = drain_q;
    wake_cnt_d  = wake_cnt_q;
`ifdef CAM_PART_INIT_EN
    init_start  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (reqValid_i && ((to_gate_w | to_ungate_w) != '0)) begin
          req_d       = req_w;
          to_gate_d   = to_gate_w;
          to_ungate_d = to_ungate_w;
          if (to_gate_w != '0) begin
            state_d = S_DRAIN;
            drain_d = to_gate_w;
          end else begin
            state_d = S_UNGATE;
            gated_d = gated_q & ~to_ungate_w;
          end
        end
      end
      S_DRAIN: begin
        if ((partEmpty_i & to_gate_q) == to_gate_q) begin
          state_d = S_GATE;
          gated_d = gated_q | to_gate_q;
          drain_d = '0;
        end
      end
      S_GATE: begin
        if (to_ungate_q != '0) begin
          state_d = S_UNGATE;
          gated_d = gated_q & ~to_ungate_q;
        end else begin
          state_d  = S_IDLE;
          active_d = req_q;
        end
      end
      S_UNGATE: begin
        state_d    = S_WAKE;
        wake_cnt_d = '0;
      end
      S_WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          wake_cnt_d = '0;
`ifdef CAM_PART_INIT_EN
          state_d    = S_INIT;
          init_start = 1'b1;
`else
          state_d    = S_IDLE;
          active_d   = req_q;
`endif
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
`ifdef CAM_PART_INIT_EN
      S_INIT: begin
        if (init_done) begin
          state_d  = S_IDLE;
          active_d = req_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Controller registers; reset aborts any transition in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      active_q    <= '1;
      req_q       <= '1;
      to_gate_q   <= '0;
      to_ungate_q <= '0;
      gated_q     <= '0;
      drain_q     <= '0;
      wake_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      req_q       <= req_d;
      to_gate_q   <= to_gate_d;
      to_ungate_q <= to_ungate_d;
      gated_q     <= gated_d;
      drain_q     <= drain_d;
      wake_cnt_q  <= wake_cnt_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign reqReady_o       = ~busy;
  assign busy_o           = busy;
  assign drainReq_o       = drain_q;
  assign partitionGated_o = gated_q;
  assign partReady_o      = active_q & ~(busy ? (to_gate_q | to_ungate_q) : '0)
                          & {NUM_PARTS{ramReady_i}};

`ifdef CAM_PART_INIT_EN
  cam_part_init_walker #(
    .DEPTH         (DEPTH),
    .INDEX         (INDEX),
    .NUM_PARTS     (NUM_PARTS),
    .NUM_PARTS_LOG (NUM_PARTS_LOG),
    .WIDTH         (WIDTH),
    .SEQ_MODE      (RESET_SEQ),
    .SEQ_START     (SEQ_START)
  ) u_init_walker (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (init_start),
    .mask_i  (to_ungate_q),
    .gnt_i   (initWrGnt_i),
    .wr_en_o (initWrEn_o),
    .addr_o  (initAddr_o),
    .data_o  (initData_o),
    .done_o  (init_done)
  );
`else
  assign initWrEn_o = 1'b0;
  assign initAddr_o = '0;
  assign initData_o = '0;

  logic unused_cfg;
  assign unused_cfg = initWrGnt_i ^ ((DEPTH + NUM_PARTS_LOG + RESET_SEQ + SEQ_START) > 0);
`endif

endmodule

// File: tb/tb_cam_part_gate_ctrl.sv
// tb/tb_cam_part_gate_ctrl.sv - scoreboard bench for cam_part_gate_ctrl; init-write checks active with CAM_PART_INIT_EN
module tb_cam_part_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reqValid_i = 1'b0;
  logic [3:0] partActiveReq_i = 4'b0;
  logic       reqReady_o;
  logic [3:0] partEmpty_i = 4'b0;
  logic [3:0] drainReq_o;
  logic [3:0] partitionGated_o;
  logic       initWrEn_o;
  logic [4:0] initAddr_o;
  logic [7:0] initData_o;
  logic       initWrGnt_i = 1'b0;
  logic       ramReady_i = 1'b1;
  logic [3:0] partReady_o;
  logic       busy_o;

  typedef struct packed {
    logic [3:0] gated;
    logic [3:0] ready;
  } exp_t;

  exp_t sb_q[$];
  int   wq[$];
  int   tests = 0;
  int   fails = 0;
  int   wr_seen = 0;
  logic prev_busy = 1'b0;
  logic in_abort = 1'b0;
  logic gnt_alt = 1'b0;

  cam_part_gate_ctrl #(
    .DEPTH(32), .INDEX(5), .NUM_PARTS(4), .NUM_PARTS_LOG(2), .WIDTH(8),
    .RESET_SEQ(1), .SEQ_START(0), .WAKE_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .reqValid_i       (reqValid_i),
    .partActiveReq_i  (partActiveReq_i),
    .reqReady_o       (reqReady_o),
    .partEmpty_i      (partEmpty_i),
    .drainReq_o       (drainReq_o),
    .partitionGated_o (partitionGated_o),
    .initWrEn_o       (initWrEn_o),
    .initAddr_o       (initAddr_o),
    .initData_o       (initData_o),
    .initWrGnt_i      (initWrGnt_i),
    .ramReady_i       (ramReady_i),
    .partReady_o      (partReady_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_req(input logic [3:0] m);
    reqValid_i      = 1'b1;
    partActiveReq_i = m;
    step();
    reqValid_i      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (!busy_o) return;
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_writes(input int first, input int last);
    for (int a = first; a <= last; a++) wq.push_back(a);
  endtask

  // Grant driver: away from the active edge, either always granted or alternating
  initial begin
    forever begin
      @(posedge clk);
      #1;
      initWrGnt_i = gnt_alt ? ~initWrGnt_i : 1'b1;
    end
  end

  // Monitor: checks every granted init write and every completed transition
  always @(negedge clk) begin
    if (reset_n) begin
      if (initWrEn_o && initWrGnt_i) begin
        wr_seen++;
        if (wq.size() == 0) begin
          chk("init_unexpected", {27'd0, initAddr_o}, 32'hffff_ffff);
        end else begin
          int e;
          e = wq.pop_front();
          chk("init_addr", {27'd0, initAddr_o}, e);
          chk("init_data", {24'd0, initData_o}, e);
        end
      end
      if (prev_busy && !busy_o && !in_abort) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", {28'd0, partitionGated_o}, 32'hffff_ffff);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          chk("final_gated", {28'd0, partitionGated_o}, {28'd0, x.gated});
          chk("final_ready", {28'd0, partReady_o}, {28'd0, x.ready});
        end
      end
    end
    prev_busy = busy_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_reqReady", reqReady_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_gated", partitionGated_o, 0);
    chk("rst_drain", drainReq_o, 0);
    chk("rst_initWrEn", initWrEn_o, 0);
    chk("rst_initAddr", initAddr_o, 0);
    chk("rst_initData", initData_o, 0);
    chk("rst_partReady", partReady_o, 4'b1111);
    reset_n = 1'b1;
    step();

    // No-change request leaves the controller idle
    send_req(4'b1111);
    chk("nochg_reqReady", reqReady_o, 1);
    chk("nochg_busy", busy_o, 0);
    chk("nochg_gated", partitionGated_o, 0);
    chk("nochg_drain", drainReq_o, 0);
    chk("nochg_partReady", partReady_o, 4'b1111);

    // Gate with drain, plus an ignored overlapping request
    partEmpty_i = 4'b0000;
    sb_q.push_back('{gated: 4'b1100, ready: 4'b0011});
    send_req(4'b0011);
    for (int i = 0; i < 10; i++) begin
      chk("drain_req", drainReq_o, 4'b1100);
      chk("drain_partReady", partReady_o, 4'b0011);
      chk("drain_reqReady", reqReady_o, 0);
      if (i == 3) begin
        reqValid_i      = 1'b1;
        partActiveReq_i = 4'b1111;
      end
      if (i == 4) reqValid_i = 1'b0;
      step();
    end
    partEmpty_i = 4'b1100;
    step();
    chk("gate_gated", partitionGated_o, 4'b1100);
    chk("gate_drain", drainReq_o, 4'b0000);
    wait_idle(50);
    partEmpty_i = 4'b0000;
    ramReady_i = 1'b0;
    #1;
    chk("ram_not_ready", partReady_o, 4'b0000);
    ramReady_i = 1'b1;
    #1;
    chk("ram_ready", partReady_o, 4'b0011);

    // Ungate back to all partitions
    gnt_alt = 1'b0;
`ifdef CAM_PART_INIT_EN
    push_writes(16, 31);
`endif
    sb_q.push_back('{gated: 4'b0000, ready: 4'b1111});
    send_req(4'b1111);
    wait_idle(100);
    chk("ungate_all_writes_left", wq.size(), 0);

    // Zero request keeps only partition 0
    partEmpty_i = 4'b1111;
    sb_q.push_back('{gated: 4'b1110, ready: 4'b0001});
    send_req(4'b0000);
    chk("zero_drain", drainReq_o, 4'b1110);
    wait_idle(50);
    partEmpty_i = 4'b0000;

    // Ungate one partition; alternating grants throttle the init walk
    gnt_alt = 1'b1;
`ifdef CAM_PART_INIT_EN
    push_writes(16, 23);
`endif
    sb_q.push_back('{gated: 4'b1010, ready: 4'b0101});
    send_req(4'b0100);
    chk("ungate_busy", busy_o, 1);
    chk("ungate_partReady", partReady_o, 4'b0001);
    wait_idle(100);
    chk("ungate_one_writes_left", wq.size(), 0);

    // Reset in the middle of a transition
    gnt_alt  = 1'b0;
    in_abort = 1'b1;
`ifdef CAM_PART_INIT_EN
    push_writes(8, 15);
    push_writes(24, 31);
    begin
      int base;
      bit hit;
      base = wr_seen;
      hit  = 1'b0;
      send_req(4'b1111);
      for (int n = 0; n < 60; n++) begin
        if (wr_seen >= base + 2 && initWrEn_o) begin
          hit = 1'b1;
          break;
        end
        step();
      end
      chk("abort_reached_write3", hit, 1);
    end
`else
    send_req(4'b1111);
    step();
    step();
    chk("abort_busy_before", busy_o, 1);
`endif
    reset_n = 1'b0;
    step();
    chk("abort_busy", busy_o, 0);
    chk("abort_reqReady", reqReady_o, 1);
    chk("abort_gated", partitionGated_o, 4'b0000);
    chk("abort_initWrEn", initWrEn_o, 0);
    chk("abort_drain", drainReq_o, 4'b0000);
    chk("abort_partReady", partReady_o, 4'b1111);
    reset_n = 1'b1;
    wq.delete();
    step();
    step();
    in_abort = 1'b0;
    chk("post_abort_busy", busy_o, 0);

`ifndef CAM_PART_INIT_EN
    chk("no_init_writes", wr_seen, 0);
`endif
    chk("sb_left", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_part_gate_ctrl.md
CAM_PART_GATE_CTRL -- requirements
Module: cam_part_gate_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, default 32, total CAM entries; INDEX, default 5, log2(DEPTH); NUM_PARTS, default 4, partition count; NUM_PARTS_LOG, default 2; WIDTH, default 8, entry data width; RESET_SEQ, default 0, where 1 writes sequential data and 0 writes zero; SEQ_START, default 0; WAKE_CYCLES, default 4, settle delay after ungating.
REQ-002 The block SHALL use one clock, clk; reset is reset_n, synchronous and active-low.
REQ-003 clk  in  1  clock.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 reqValid_i  in  1  new active-partition mask offered.
REQ-006 partActiveReq_i  in  NUM_PARTS  requested active mask.
REQ-007 reqReady_o  out  1  controller can accept a request.
REQ-008 partEmpty_i  in  NUM_PARTS  partition holds no live entries.
REQ-009 drainReq_o  out  NUM_PARTS  stop allocating into and drain this partition.
REQ-010 partitionGated_o  out  NUM_PARTS  power-gate control to the partitioned CAM.
REQ-011 initWrEn_o  out  1, initAddr_o  out  INDEX, initData_o  out  WIDTH: reinit write request.
REQ-012 initWrGnt_i  in  1  write port granted this cycle.
REQ-013 ramReady_i  in  1  CAM ready.
REQ-014 partReady_o  out  NUM_PARTS  partition usable for allocation.
REQ-015 busy_o  out  1  transition in progress.

Function
REQ-016 FSM states SHALL be IDLE, DRAIN, GATE, UNGATE, WAKE, INIT.
REQ-017 In IDLE, reqReady_o SHALL be 1; in all other states it SHALL be 0, and busy_o SHALL be its inverse.
REQ-018 On reqValid_i&&reqReady_o, the block SHALL latch req = partActiveReq_i|1, forcing bit 0 on, then set toGate = active&~req and toUngate = ~active&req.
REQ-019 If toGate=0 and toUngate=0, the FSM SHALL stay in IDLE with no output change.
REQ-020 If toGate!=0, the next state SHALL be DRAIN; otherwise it SHALL be UNGATE.
REQ-021 In DRAIN, drainReq_o SHALL equal toGate, and partReady_o[toGate] SHALL be 0 from the first DRAIN cycle.
REQ-022 The FSM SHALL leave DRAIN only when (partEmpty_i&toGate)==toGate.
REQ-023 GATE SHALL last 1 cycle: it sets partitionGated_o|=toGate and clears drainReq_o; the next state SHALL be UNGATE if toUngate!=0, else IDLE.
REQ-024 UNGATE SHALL last 1 cycle, clearing partitionGated_o bits for toUngate; the next state SHALL be WAKE.
REQ-025 WAKE SHALL count WAKE_CYCLES cycles, then go to INIT if CAM_PART_INIT_EN is defined, else IDLE.
REQ-026 INIT SHALL walk the toUngate partitions in ascending order and, within each partition, entries 0..DEPTH/NUM_PARTS-1.
REQ-027 In INIT, initAddr_o SHALL equal {part, entry} and initData_o SHALL equal RESET_SEQ ? (SEQ_START+initAddr_o) truncated to WIDTH : 0.
REQ-028 initWrEn_o SHALL be held until initWrGnt_i; the walker SHALL advance only on a grant cycle.
REQ-029 The last grant SHALL return the FSM to IDLE.
REQ-030 On return to IDLE, active SHALL become req.
REQ-031 partReady_o SHALL equal active & ~(toGate|toUngate while busy) & {NUM_PARTS{ramReady_i}}.
REQ-032 reqValid_i while busy SHALL be ignored, with no queueing.
REQ-033 An all-zero partActiveReq_i SHALL result in only partition 0 remaining active.

Reset
REQ-034 On reset_n=0 at a clk edge: state IDLE; active all ones; partitionGated_o 0; drainReq_o 0; initWrEn_o 0; initAddr_o 0; initData_o 0; counters 0.
REQ-035 Reset during any state SHALL abort the operation and apply REQ-034 values on the next edge.

Configuration
REQ-036 Macro CAM_PART_INIT_EN: when defined, ungated partitions SHALL be rewritten through INIT before becoming ready.
REQ-037 When CAM_PART_INIT_EN is undefined, there SHALL be no INIT state, initWrEn_o SHALL be tied 0, and WAKE SHALL go directly to IDLE.

Structure
REQ-038 Package cam_part_ctrl_pkg SHALL hold the state enum type and the RESET_SEQ/RESET_ZERO constants.
REQ-039 The INIT address/data walker SHALL be the sub-module cam_part_init_walker, instantiated only under CAM_PART_INIT_EN.

Verification
REQ-040 Gate with drain: active=1111, request 0011, partEmpty_i=0000 for 10 cycles then 1100 -> drainReq_o=1100 throughout, partitionGated_o=1100 one cycle after empty, partReady_o=0011.
REQ-041 Ungate with init (CAM_PART_INIT_EN, RESET_SEQ=1, SEQ_START=0): active 0001, request 0100, initWrGnt_i every other cycle -> 8 writes, addr 16..23, data 16..23, then partReady_o=0101.
REQ-042 Zero request: request 0000 from 1111 -> final active 0001, partitionGated_o=1110.
REQ-043 Busy overlap: second reqValid_i during DRAIN -> ignored; final mask equals the first request.
REQ-044 Mid-INIT reset: reset_n=0 at the third write -> next cycle IDLE, partitionGated_o=0000, initWrEn_o=0.
REQ-045 No-change request: request equals active -> reqReady_o remains 1, no output toggles.
